sipo_register: RTL and testbench
================================

SIPO_REGISTER -- requirements
Module: sipo_register

Interface
REQ-001 The block SHALL have one parameter: N, default 8, shift-register width in bits (N >= 2).
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port sin SHALL be: sin  input  1  serial data in, sampled on each rising clk edge.
REQ-005 Port pout SHALL be: pout  output  N  parallel view of the N most recent sampled sin bits.
REQ-006 The block SHALL have no other ports and no enable, load or valid signals; it shifts on every clock edge while out of reset.

Function
REQ-007 The block SHALL hold one N-bit register, and pout SHALL drive that register directly (registered output, no combinational path from sin to pout).
REQ-008 On each rising clk edge with rst_n=1, the register SHALL shift toward the MSB: new pout = {old pout[N-2:0], sin}.
REQ-009 The first bit of a serial word (MSB-first transmission) SHALL end up in pout[N-1] after exactly N shifts; the last bit SHALL end up in pout[0].
REQ-010 Latency SHALL be one clock: a bit sampled on edge k SHALL appear in pout[0] immediately after edge k.
REQ-011 The bit in pout[N-1] SHALL be discarded on each shift; there is no overflow flag and no word framing.
REQ-012 Back-to-back words SHALL need no gap cycles; after N further shifts, pout SHALL hold only the new word.
REQ-013 Every edge SHALL shift, including edges inside a word; partial-word contents SHALL be visible on pout.
REQ-014 Width rule: all N bits SHALL shift together; there is no arithmetic, sign extension or saturation.

Reset
REQ-015 On a rising clk edge with rst_n=0, pout SHALL become all zeros, and sin SHALL be ignored on that edge.
REQ-016 Reset SHALL take priority over shifting on the same edge.
REQ-017 Reset SHALL be synchronous only: an rst_n change between edges SHALL NOT affect pout until the next rising edge.
REQ-018 Reset asserted mid-word SHALL discard all partial data; shifting SHALL resume from zero on the first edge with rst_n=1.
REQ-019 Before the first reset edge, pout is undefined; an implementation SHALL NOT depend on power-up values.

Verification
REQ-020 Reset test: set rst_n=0 and sin=0 for one edge -> pout=8'h00.
REQ-021 Serial load test: after reset, shift 1,0,1,1,0,1,0,1 (one bit per edge) -> pout=8'hB5 after the 8th edge.
REQ-022 Back-to-back word test: with no gap after the previous word, shift 0,1,0,1,0,0,1,1 -> pout=8'h53 after the 8th edge.
REQ-023 Partial word test: after reset, shift 1,1,1 -> pout=8'h07 after 3 edges.
REQ-024 Reset mid-word test: shift 1,1, then set rst_n=0 for one edge while sin=1 -> pout=8'h00; then shift 1 with rst_n=1 -> pout=8'h01.
REQ-025 Sync reset test: pulse rst_n low between edges only, not across a rising edge -> pout unchanged and shifting continues normally.

Source files
------------

// File: rtl/sipo_register.sv
// Serial-in parallel-out shift register, MSB-first word assembly.
// Shifts on every rising edge; synchronous active-low clear.
module sipo_register #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sin,
  output logic [N-1:0] pout
);

  logic [N-1:0] shift_q;
  logic [N-1:0] shift_d;

  // Clear wins over shifting; sin is ignored on a clear edge.
  always_comb begin
    shift_d = {shift_q[N-2:0], sin};
    if (!rst_n) begin
      shift_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign pout = shift_q;

endmodule

// File: tb/tb_sipo_register.sv
// Bench for sipo_register: directed vectors plus randomized
// traffic against a bit-history reference model.
module tb_sipo_register;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         sin;
  logic [N-1:0] pout;

  int ntests;
  int nfail;
  bit hist[$];

  sipo_register #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sin  (sin),
    .pout (pout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word: the most recent N sampled bits since reset,
  // newest in bit 0, missing history reads as zero.
  function automatic logic [N-1:0] model_word();
    logic [N-1:0] w;
    int sz;
    w = '0;
    sz = hist.size();
    for (int i = 0; i < N; i++) begin
      if (i < sz) w[i] = hist[sz-1-i];
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [N-1:0] exp);
    ntests++;
    assert (pout === exp) else begin
      nfail++;
      $error("FAIL %s: pout=%h expected=%h", tag, pout, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input string tag);
    rst_n = r;
    sin   = s;
    @(posedge clk);
    if (!r) hist.delete();
    else begin
      hist.push_back(s);
      if (hist.size() > N) void'(hist.pop_front());
    end
    #1;
    check(tag, model_word());
  endtask

  task automatic shift_word(input logic [N-1:0] w, input string tag);
    for (int i = N - 1; i >= 0; i--) step(1'b1, w[i], tag);
  endtask

  initial begin
    logic [N-1:0] held;
    ntests = 0;
    nfail  = 0;
    rst_n  = 1'b0;
    sin    = 1'b0;
    #2;

    step(1'b0, 1'b0, "reset");
    check("reset_lit", 8'h00);

    shift_word(8'hB5, "load");
    check("load_lit", 8'hB5);

    shift_word(8'h53, "b2b");
    check("b2b_lit", 8'h53);

    step(1'b0, 1'b0, "reset2");
    step(1'b1, 1'b1, "part");
    check("part1_lit", 8'h01);
    step(1'b1, 1'b1, "part");
    step(1'b1, 1'b1, "part");
    check("part3_lit", 8'h07);

    step(1'b0, 1'b0, "reset3");
    step(1'b1, 1'b1, "mid");
    step(1'b1, 1'b1, "mid");
    check("mid2_lit", 8'h03);
    step(1'b0, 1'b1, "midrst");
    check("midrst_lit", 8'h00);
    step(1'b1, 1'b1, "resume");
    check("resume_lit", 8'h01);

    // Low pulse entirely between edges must not clear.
    step(1'b1, 1'b0, "pre");
    step(1'b1, 1'b1, "pre");
    held = pout;
    #1 rst_n = 1'b0;
    #2;
    check("pulse_low", held);
    rst_n = 1'b1;
    #2;
    check("pulse_high", held);
    step(1'b1, 1'b1, "post");
    check("post_lit", 8'h0B);

    // All-ones fill then discard of the top bit.
    shift_word(8'hFF, "ones");
    check("ones_lit", 8'hFF);
    step(1'b1, 1'b0, "drop");
    check("drop_lit", 8'hFE);

    for (int k = 0; k < 300; k++) begin
      logic r;
      r = ($urandom_range(0, 19) != 0);
      step(r, 1'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
